// File: rtl/cmos_pkg.sv
// -----------------------------------------------------------------------------
// cmos_pkg
// Shared definitions for the OV7670 pixel capture path:
//   - cap_state_e : capture FSM state encoding (WAIT_CFG=0, WAIT_FRAME=1,
//                   CAPTURE=2)
//   - DEF_H_ACTIVE / DEF_V_ACTIVE / DEF_ADDR_W : default frame geometry
//     (640x480, 19-bit linear address)
// -----------------------------------------------------------------------------
package cmos_pkg;

    typedef enum logic [1:0] {
        WAIT_CFG   = 2'd0,
        WAIT_FRAME = 2'd1,
        CAPTURE    = 2'd2
    } cap_state_e;

    localparam int unsigned DEF_H_ACTIVE = 32'd640;
    localparam int unsigned DEF_V_ACTIVE = 32'd480;
    localparam int unsigned DEF_ADDR_W   = 32'd19;

endpackage

// File: rtl/cmos_sync_edge.sv
// -----------------------------------------------------------------------------
// cmos_sync_edge
// Two-flop synchroniser for one asynchronous camera signal, followed by a
// delay flop used for edge detection. The edge strobes are registered, and
// level_o is the delayed copy, so level and edges are all aligned three
// clock cycles behind the pin.
// Ports:
//   clk_i   : system clock
//   rst_n_i : asynchronous active-low reset (all flops clear to 0)
//   async_i : asynchronous input
//   level_o : synchronised level, aligned with the edge strobes
//   rise_o  : one-cycle strobe on a synchronised rising edge
//   fall_o  : one-cycle strobe on a synchronised falling edge
// -----------------------------------------------------------------------------
module cmos_sync_edge (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic dly_q;
    logic rise_q;
    logic fall_q;

    // Synchroniser chain plus registered edge detect.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
            rise_q <= sync_q & ~dly_q;
            fall_q <= ~sync_q & dly_q;
        end
    end

    assign level_o = dly_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/cmos_pixel_capture.sv
// -----------------------------------------------------------------------------
// cmos_pixel_capture
// Captures the OV7670 RGB444 (xR GB) byte stream in the clk_100MHz domain,
// pairs bytes into 12-bit pixels and emits one frame-buffer write per pixel
// with a linear address (line*H_ACTIVE + column, kept as a running counter).
//
// Optional build macro CAPTURE_DECIMATE_EN: when defined only even-column,
// even-line pixels are written, packed into an (H/2)x(V/2) buffer.
//
// Ports:
//   clk_100MHz : system clock (only clock)
//   rst_n      : asynchronous active-low reset
//   cfg_done   : camera configuration finished (level)
//   cmos_pclk, cmos_vsync, cmos_href, cmos_d[7:0] : asynchronous camera bus
//   pix_wr_en  : one-cycle write strobe
//   pix_addr   : linear write address (registered, held between writes)
//   pix_data   : {R,G,B} 4 bits each (registered, held between writes)
//   frame_done : one-cycle pulse at the vsync rise ending a captured frame
//   capturing  : high while the FSM is in CAPTURE
// -----------------------------------------------------------------------------
module cmos_pixel_capture
    import cmos_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
    input  logic              clk_100MHz,
    input  logic              rst_n,
    input  logic              cfg_done,
    input  logic              cmos_pclk,
    input  logic              cmos_vsync,
    input  logic              cmos_href,
    input  logic [7:0]        cmos_d,
    output logic              pix_wr_en,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [11:0]       pix_data,
    output logic              frame_done,
    output logic              capturing
);

    localparam int unsigned COL_W  = $clog2(H_ACTIVE + 32'd1);
    localparam int unsigned LINE_W = $clog2(V_ACTIVE + 32'd1);

    localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(H_ACTIVE);
    localparam logic [COL_W-1:0]  COL_ONE   = COL_W'(1);
    localparam logic [COL_W-1:0]  COL_ZERO  = COL_W'(0);
    localparam logic [LINE_W-1:0] LINE_MAX  = LINE_W'(V_ACTIVE);
    localparam logic [LINE_W-1:0] LINE_ONE  = LINE_W'(1);
    localparam logic [LINE_W-1:0] LINE_ZERO = LINE_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);

    // ---------------- input synchronisation ----------------
    logic pclk_lvl_s, pclk_rise_s, pclk_fall_s;
    logic vs_lvl_s, vs_rise_s, vs_fall_s;
    logic href_lvl_s, href_rise_s, href_fall_s;

    cmos_sync_edge u_sync_pclk (
        .clk_i   (clk_100MHz),
        .rst_n_i (rst_n),
        .async_i (cmos_pclk),
        .level_o (pclk_lvl_s),
        .rise_o  (pclk_rise_s),
        .fall_o  (pclk_fall_s)
    );

    cmos_sync_edge u_sync_vsync (
        .clk_i   (clk_100MHz),
        .rst_n_i (rst_n),
        .async_i (cmos_vsync),
        .level_o (vs_lvl_s),
        .rise_o  (vs_rise_s),
        .fall_o  (vs_fall_s)
    );

    cmos_sync_edge u_sync_href (
        .clk_i   (clk_100MHz),
        .rst_n_i (rst_n),
        .async_i (cmos_href),
        .level_o (href_lvl_s),
        .rise_o  (href_rise_s),
        .fall_o  (href_fall_s)
    );

    // Only some edges/levels of each synchronised signal are needed.
    logic unused_s;
    assign unused_s = &{1'b0, pclk_lvl_s, pclk_fall_s, vs_lvl_s, href_rise_s};

    logic [7:0] d_meta_q;
    logic [7:0] d_sync_q;
    logic [7:0] d_dly_q;

    // Data bus: 2-flop sync plus one alignment stage so the byte lines up
    // with the registered pclk_rise strobe.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            d_meta_q <= 8'h00;
            d_sync_q <= 8'h00;
            d_dly_q  <= 8'h00;
        end else begin
            d_meta_q <= cmos_d;
            d_sync_q <= d_meta_q;
            d_dly_q  <= d_sync_q;
        end
    end

    // ---------------- capture state ----------------
    cap_state_e         state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic               phase_q, phase_d;
    logic [3:0]         red_q, red_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic               wr_q, wr_d;
    logic               fd_q, fd_d;
    logic               cap_q, cap_d;
    logic [ADDR_W-1:0]  pix_addr_q, pix_addr_d;
    logic [11:0]        pix_data_q, pix_data_d;

    logic               pix_ok_s;
    logic [ADDR_W-1:0]  line_step_s;

`ifdef CAPTURE_DECIMATE_EN
    // Even column and even line only; only even lines advance the base.
    assign pix_ok_s    = (col_q < COL_MAX) && (line_q < LINE_MAX) &&
                         !col_q[0] && !line_q[0];
    assign line_step_s = line_q[0] ? ADDR_ZERO : ADDR_W'(H_ACTIVE / 32'd2);
`else
    assign pix_ok_s    = (col_q < COL_MAX) && (line_q < LINE_MAX);
    assign line_step_s = ADDR_W'(H_ACTIVE);
`endif

    // Next-state logic for the capture FSM, counters and output registers.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        line_d     = line_q;
        phase_d    = phase_q;
        red_d      = red_q;
        addr_d     = addr_q;
        base_d     = base_q;
        wr_d       = 1'b0;
        fd_d       = 1'b0;
        pix_addr_d = pix_addr_q;
        pix_data_d = pix_data_q;

        case (state_q)
            WAIT_CFG: begin
                state_d = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (vs_fall_s) begin
                    state_d = CAPTURE;
                end else begin
                    state_d = WAIT_FRAME;
                end
            end
            CAPTURE: begin
                if (pclk_rise_s && href_lvl_s) begin
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        red_d = d_dly_q[3:0];
                    end else begin
                        if (pix_ok_s) begin
                            wr_d       = 1'b1;
                            pix_addr_d = addr_q;
                            pix_data_d = {red_q, d_dly_q};
                            addr_d     = addr_q + ADDR_ONE;
                        end else begin
                            wr_d = 1'b0;
                        end
                        if (col_q < COL_MAX) begin
                            col_d = col_q + COL_ONE;
                        end else begin
                            col_d = col_q;
                        end
                    end
                end else begin
                    phase_d = phase_q;
                end

                // vsync rise wins over a coincident href fall; a write
                // completed above in this cycle is still emitted.
                if (vs_rise_s) begin
                    fd_d    = 1'b1;
                    state_d = WAIT_FRAME;
                end else if (href_fall_s) begin
                    phase_d = 1'b0;
                    if (col_q != COL_ZERO) begin
                        col_d = COL_ZERO;
                        if (line_q < LINE_MAX) begin
                            line_d = line_q + LINE_ONE;
                            base_d = base_q + line_step_s;
                            addr_d = base_q + line_step_s;
                        end else begin
                            line_d = line_q;
                        end
                    end else begin
                        col_d = col_q;
                    end
                end else begin
                    state_d = CAPTURE;
                end
            end
            default: begin
                state_d = WAIT_CFG;
            end
        endcase

        // Outside CAPTURE the position counters are held clear.
        if (state_q != CAPTURE) begin
            col_d   = COL_ZERO;
            line_d  = LINE_ZERO;
            phase_d = 1'b0;
            addr_d  = ADDR_ZERO;
            base_d  = ADDR_ZERO;
        end else begin
            state_d = state_d;
        end

        // Losing configuration aborts immediately, silently.
        if (!cfg_done) begin
            state_d    = WAIT_CFG;
            wr_d       = 1'b0;
            fd_d       = 1'b0;
            pix_addr_d = pix_addr_q;
            pix_data_d = pix_data_q;
        end else begin
            state_d = state_d;
        end

        cap_d = (state_d == CAPTURE);
    end

    // FSM, counters and registered outputs.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_CFG;
            col_q      <= COL_ZERO;
            line_q     <= LINE_ZERO;
            phase_q    <= 1'b0;
            red_q      <= 4'h0;
            addr_q     <= ADDR_ZERO;
            base_q     <= ADDR_ZERO;
            wr_q       <= 1'b0;
            fd_q       <= 1'b0;
            cap_q      <= 1'b0;
            pix_addr_q <= ADDR_ZERO;
            pix_data_q <= 12'h000;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            line_q     <= line_d;
            phase_q    <= phase_d;
            red_q      <= red_d;
            addr_q     <= addr_d;
            base_q     <= base_d;
            wr_q       <= wr_d;
            fd_q       <= fd_d;
            cap_q      <= cap_d;
            pix_addr_q <= pix_addr_d;
            pix_data_q <= pix_data_d;
        end
    end

    assign pix_wr_en  = wr_q;
    assign pix_addr   = pix_addr_q;
    assign pix_data   = pix_data_q;
    assign frame_done = fd_q;
    assign capturing  = cap_q;

endmodule

// File: tb/tb_cmos_pixel_capture.sv
// -----------------------------------------------------------------------------
// tb_cmos_pixel_capture
// Directed bench for cmos_pixel_capture on a reduced 8x6 frame. The camera
// is modelled at 25 MHz pclk (4 system clocks per pclk). Byte 0 of pixel
// (l,c) carries R = l+5 (upper nibble 0xF, must be discarded); byte 1 is
// c+0x30, so the expected pixel is {l+5, c+0x30}.
// Honours CAPTURE_DECIMATE_EN for the expected write counts and addresses.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cmos_pixel_capture;

    localparam int H  = 8;
    localparam int V  = 6;
    localparam int AW = 6;

`ifdef CAPTURE_DECIMATE_EN
    localparam int FRAME_WR = 12;
    localparam int T4_WR    = 5;
    localparam int T4_IA    = 3;  // last write of the long line
    localparam int T4_AA    = 3;
    localparam int T4_LA    = 0;
    localparam int T4_CA    = 6;
    localparam int T4_AB    = 4;  // single pixel on line 2
`else
    localparam int FRAME_WR = 48;
    localparam int T4_WR    = 10;
    localparam int T4_IA    = 8;  // pixel written from the odd line
    localparam int T4_AA    = 8;
    localparam int T4_LA    = 1;
    localparam int T4_CA    = 0;
    localparam int T4_AB    = 16; // single pixel on line 2
`endif

    logic          clk;
    logic          rst_n;
    logic          cfg_done;
    logic          cmos_pclk;
    logic          cmos_vsync;
    logic          cmos_href;
    logic [7:0]    cmos_d;
    logic          pix_wr_en;
    logic [AW-1:0] pix_addr;
    logic [11:0]   pix_data;
    logic          frame_done;
    logic          capturing;

    cmos_pixel_capture #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .ADDR_W   (AW)
    ) dut (
        .clk_100MHz (clk),
        .rst_n      (rst_n),
        .cfg_done   (cfg_done),
        .cmos_pclk  (cmos_pclk),
        .cmos_vsync (cmos_vsync),
        .cmos_href  (cmos_href),
        .cmos_d     (cmos_d),
        .pix_wr_en  (pix_wr_en),
        .pix_addr   (pix_addr),
        .pix_data   (pix_data),
        .frame_done (frame_done),
        .capturing  (capturing)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;

    // Write / frame_done monitor (sampled on the falling edge).
    logic [AW-1:0] log_addr[$];
    logic [11:0]   log_data[$];
    int            fd_cnt   = 0;
    int            fd_wide  = 0;
    int            wr_pairs = 0;
    logic          prev_wr  = 1'b0;
    logic          prev_fd  = 1'b0;

    always @(negedge clk) begin
        if (pix_wr_en === 1'b1) begin
            log_addr.push_back(pix_addr);
            log_data.push_back(pix_data);
        end
        if (pix_wr_en === 1'b1 && prev_wr === 1'b1) wr_pairs <= wr_pairs + 1;
        if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
        if (frame_done === 1'b1 && prev_fd === 1'b1) fd_wide <= fd_wide + 1;
        prev_wr <= pix_wr_en;
        prev_fd <= frame_done;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] exp_data(input int l, input int c);
        return {4'(l + 5), 8'(c + 48)};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        cmos_pclk = 1'b0;
        cmos_d    = b;
        tick(2);
        cmos_pclk = 1'b1;
        tick(2);
    endtask

    task automatic send_line(input int l, input int nbytes);
        cmos_href = 1'b1;
        tick(2);
        for (int i = 0; i < nbytes; i++) begin
            if (i % 2 == 0) send_byte({4'hF, 4'(l + 5)});
            else            send_byte(8'(i / 2 + 48));
        end
        cmos_pclk = 1'b0;
        cmos_href = 1'b0;
        tick(6);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    int errs;
    int el, ec;
    int fd_exp;

    initial begin
        rst_n      = 1'b0;
        cfg_done   = 1'b0;
        cmos_pclk  = 1'b0;
        cmos_vsync = 1'b1;
        cmos_href  = 1'b0;
        cmos_d     = 8'h00;
        fd_exp     = 0;
        tick(3);

        // ---- T1: reset values, bus activity ignored without cfg_done ----
        check("rst_wr_en",   32'(pix_wr_en),  32'd0);
        check("rst_addr",    32'(pix_addr),   32'd0);
        check("rst_data",    32'(pix_data),   32'd0);
        check("rst_fdone",   32'(frame_done), 32'd0);
        check("rst_capt",    32'(capturing),  32'd0);
        rst_n = 1'b1;
        tick(2);
        cmos_vsync = 1'b0;
        tick(4);
        send_line(0, 4);
        cmos_vsync = 1'b1;
        tick(6);
        check("nocfg_writes", 32'(log_addr.size()), 32'd0);
        check("nocfg_capt",   32'(capturing),       32'd0);
        cfg_done = 1'b1;
        tick(4);
        check("waitframe_capt", 32'(capturing), 32'd0);
        cmos_vsync = 1'b0;
        tick(6);
        check("vsfall_capt", 32'(capturing), 32'd1);

        // ---- T2: first pixel 0x0A,0xBC -> 0xABC @0, 4-cycle latency ----
        cmos_href = 1'b1;
        tick(2);
        send_byte(8'h0A);
        cmos_pclk = 1'b0;
        cmos_d    = 8'hBC;
        tick(2);
        cmos_pclk = 1'b1;
        tick(3);
        check("lat_wr_early", 32'(pix_wr_en), 32'd0);
        tick(1);
        check("lat_wr_en",    32'(pix_wr_en), 32'd1);
        check("first_data",   32'(pix_data),  32'h0ABC);
        check("first_addr",   32'(pix_addr),  32'd0);
        tick(1);
        check("wr_one_cycle", 32'(pix_wr_en), 32'd0);
        check("data_hold",    32'(pix_data),  32'h0ABC);
        cmos_pclk = 1'b0;
        cmos_href = 1'b0;
        tick(6);
        cmos_vsync = 1'b1;
        fd_exp++;
        tick(8);
        check("t2_fd_cnt",  32'(fd_cnt),    32'(fd_exp));
        check("t2_capt",    32'(capturing), 32'd0);

        // ---- T3: full frame ----
        clear_log();
        cmos_vsync = 1'b0;
        tick(6);
        for (int l = 0; l < V; l++) send_line(l, 2 * H);
        cmos_vsync = 1'b1;
        fd_exp++;
        tick(8);
        check("frame_writes", 32'(log_addr.size()), 32'(FRAME_WR));
        check("frame_last_addr", 32'(log_addr[FRAME_WR-1]), 32'(FRAME_WR - 1));
        errs = 0;
        for (int k = 0; k < FRAME_WR && k < log_addr.size(); k++) begin
`ifdef CAPTURE_DECIMATE_EN
            el = 2 * (k / (H / 2));
            ec = 2 * (k % (H / 2));
`else
            el = k / H;
            ec = k % H;
`endif
            if (log_addr[k] !== AW'(k) || log_data[k] !== exp_data(el, ec)) errs++;
        end
        check("frame_seq_errs", 32'(errs),     32'd0);
        check("frame_fd_cnt",   32'(fd_cnt),   32'(fd_exp));
        check("fd_single",      32'(fd_wide),  32'd0);
        check("wr_no_pairs",    32'(wr_pairs), 32'd0);

        // ---- T4: over-long line, odd-byte line, then one pixel ----
        clear_log();
        cmos_vsync = 1'b0;
        tick(6);
        send_line(0, 2 * (H + 1));
        send_line(1, 3);
        send_line(2, 2);
        cmos_vsync = 1'b1;
        fd_exp++;
        tick(8);
        check("t4_writes", 32'(log_addr.size()), 32'(T4_WR));
        check("t4_addr_a", 32'(log_addr[T4_IA]),     32'(T4_AA));
        check("t4_data_a", 32'(log_data[T4_IA]),     32'(exp_data(T4_LA, T4_CA)));
        check("t4_addr_b", 32'(log_addr[T4_WR-1]),   32'(T4_AB));
        check("t4_data_b", 32'(log_data[T4_WR-1]),   32'(exp_data(2, 0)));

        // ---- T5: reset mid-line, resume at address 0 on next frame ----
        cmos_vsync = 1'b0;
        tick(6);
        send_line(0, 2 * H);
        cmos_href = 1'b1;
        tick(2);
        send_byte(8'hF6);
        send_byte(8'h30);
        send_byte(8'hF6);
        rst_n = 1'b0;
        tick(1);
        check("mid_rst_wr",   32'(pix_wr_en),  32'd0);
        check("mid_rst_addr", 32'(pix_addr),   32'd0);
        check("mid_rst_data", 32'(pix_data),   32'd0);
        check("mid_rst_capt", 32'(capturing),  32'd0);
        tick(2);
        rst_n = 1'b1;
        clear_log();
        send_byte(8'h31);
        send_byte(8'hF6);
        send_byte(8'h32);
        cmos_pclk = 1'b0;
        cmos_href = 1'b0;
        tick(6);
        check("post_rst_nowr", 32'(log_addr.size()), 32'd0);
        cmos_vsync = 1'b1;
        tick(8);
        cmos_vsync = 1'b0;
        tick(6);
        send_line(0, 2);
        check("resume_writes", 32'(log_addr.size()), 32'd1);
        check("resume_addr",   32'(log_addr[0]),     32'd0);
        check("resume_data",   32'(log_data[0]),     32'(exp_data(0, 0)));

        // ---- T6: cfg_done drop aborts without frame_done ----
        check("pre_drop_capt", 32'(capturing), 32'd1);
        cfg_done = 1'b0;
        tick(2);
        check("drop_capt", 32'(capturing), 32'd0);
        cmos_vsync = 1'b1;
        tick(8);
        check("drop_no_fd", 32'(fd_cnt), 32'(fd_exp));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
